// File: rtl/shift_register_n.sv
`default_nettype none
// ============================================================================
// Module      : shift_register_n
// Description : N-bit parallel-load / serial-shift register with transfer
//               control. A load captures d and starts a transfer; each
//               shift_en cycle advances one bit position until N shifts
//               have completed, at which point done pulses for one cycle
//               and the block returns to idle.
//
// Ports       : clk      - clock, all state updates on the rising edge
//               reset    - asynchronous, active-low reset
//               clear    - synchronous clear of all state (highest priority)
//               load     - parallel load of d, starts or restarts a transfer
//               d        - parallel load data, N bits
//               shift_en - advance one bit position this cycle (SHIFT only)
//               sin      - serial data in
//               q        - register contents
//               sout     - serial data out, combinational from q
//               count    - shifts completed in the current transfer
//               busy     - high while a transfer is in progress
//               done     - one-cycle pulse when the transfer completes
//
// Revision    : 1.0 - initial release
// ============================================================================
module shift_register_n #(
    parameter int N         = 8,    // register width in bits, N >= 2
    parameter bit MSB_FIRST = 1'b1  // 1: shift toward MSB, 0: toward LSB
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load,
    input  logic [N-1:0]             d,
    input  logic                     shift_en,
    input  logic                     sin,
    output logic [N-1:0]             q,
    output logic                     sout,
    output logic [$clog2(N+1)-1:0]   count,
    output logic                     busy,
    output logic                     done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CW = $clog2(N+1);

    // State encoding
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    // Count value at which the next shift is the final one of the transfer
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N-1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [0:0]      w_next_state;
    logic [N-1:0]    r_q;
    logic [c_CW-1:0] r_count;
    logic            r_done;

    logic [N-1:0]    w_shifted;     // r_q advanced by one position with sin
    logic            w_sout;
    logic            w_shift_fire;  // a shift actually happens this cycle
    logic            w_last_shift;  // this shift completes the transfer
    logic            w_busy;

    // ------------------------------------------------------------------------
    // Shift direction selection. The serial output is always the bit that
    // will leave the register on the next shift.
    // ------------------------------------------------------------------------
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_q[N-2:0], sin};
            assign w_sout    = r_q[N-1];
        end else begin : g_lsb_first
            assign w_shifted = {sin, r_q[N-1:1]};
            assign w_sout    = r_q[0];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. Priority is clear > load > shift_en; a load is
    // accepted in either state, so a load during SHIFT simply restarts.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = c_IDLE;
        end else if (load) begin
            w_next_state = c_SHIFT;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_next_state = c_IDLE;
                end
                c_SHIFT: begin
                    if (w_last_shift) begin
                        w_next_state = c_IDLE;
                    end
                end
                default: begin
                    w_next_state = c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output / decode logic. busy is a pure decode of the state. The
    // shift qualifiers ignore clear/load; those are resolved by priority in
    // the datapath and next-state logic.
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy       = 1'b0;
        w_shift_fire = 1'b0;
        w_last_shift = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_busy = 1'b0;
            end
            c_SHIFT: begin
                w_busy       = 1'b1;
                w_shift_fire = shift_en;
                w_last_shift = shift_en && (r_count == c_LAST);
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: shift register, transfer counter and done pulse.
    // count only advances while in SHIFT and SHIFT is left on the shift that
    // reaches N, so count saturates at N and can never wrap. done is
    // registered and defaults low every cycle, which makes it a single-cycle
    // pulse; clear and load both suppress it, so a restarted or cleared
    // transfer never reports completion.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (clear) begin
            r_q     <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (load) begin
            r_q     <= d;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (w_shift_fire) begin
            r_q     <= w_shifted;
            r_count <= r_count + c_ONE;
            r_done  <= w_last_shift;
        end else begin
            // Stall in SHIFT or any cycle in IDLE: hold data, drop done.
            r_done  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign q     = r_q;
    assign sout  = w_sout;
    assign count = r_count;
    assign busy  = w_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_register_n
// Description : Self-checking bench for shift_register_n. Two instances
//               (MSB-first and LSB-first, N=8) share one stimulus stream.
//               Each applied cycle pushes its expected outputs into a queue;
//               the record is popped and compared once the DUT has updated.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_register_n;

    localparam int N  = 8;
    localparam int CW = $clog2(N+1);

    logic          clk;
    logic          reset;
    logic          clear;
    logic          load;
    logic [N-1:0]  d;
    logic          shift_en;
    logic          sin;

    logic [N-1:0]  q_m,     q_l;
    logic          sout_m,  sout_l;
    logic [CW-1:0] count_m, count_l;
    logic          busy_m,  busy_l;
    logic          done_m,  done_l;

    shift_register_n #(.N(N), .MSB_FIRST(1'b1)) dut_m (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .load     (load),
        .d        (d),
        .shift_en (shift_en),
        .sin      (sin),
        .q        (q_m),
        .sout     (sout_m),
        .count    (count_m),
        .busy     (busy_m),
        .done     (done_m)
    );

    shift_register_n #(.N(N), .MSB_FIRST(1'b0)) dut_l (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .load     (load),
        .d        (d),
        .shift_en (shift_en),
        .sin      (sin),
        .q        (q_l),
        .sout     (sout_l),
        .count    (count_l),
        .busy     (busy_l),
        .done     (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One stimulus cycle and the outputs expected after its clock edge
    typedef struct {
        logic          clear;
        logic          load;
        logic [N-1:0]  d;
        logic          shift_en;
        logic          sin;
        logic [N-1:0]  eq_m;
        logic [N-1:0]  eq_l;
        logic [CW-1:0] ecount;
        logic          ebusy;
        logic          edone;
        logic          esout_m;
        logic          esout_l;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic c, input logic l, input logic [N-1:0] dd,
                                input logic se, input logic si,
                                input logic [N-1:0] qm, input logic [N-1:0] ql,
                                input int cnt, input logic b, input logic dn,
                                input logic som, input logic sol);
        vec_t v;
        v.clear = c;   v.load = l;   v.d = dd;   v.shift_en = se; v.sin = si;
        v.eq_m = qm;   v.eq_l = ql;  v.ecount = CW'(cnt);
        v.ebusy = b;   v.edone = dn; v.esout_m = som; v.esout_l = sol;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare both instances against it
    task automatic compare_head(input int idx);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue expected a record", idx);
            return;
        end
        e = sb.pop_front();
        chk("q_msb",     idx, 32'(q_m),     32'(e.eq_m));
        chk("q_lsb",     idx, 32'(q_l),     32'(e.eq_l));
        chk("count_msb", idx, 32'(count_m), 32'(e.ecount));
        chk("count_lsb", idx, 32'(count_l), 32'(e.ecount));
        chk("busy_msb",  idx, 32'(busy_m),  32'(e.ebusy));
        chk("busy_lsb",  idx, 32'(busy_l),  32'(e.ebusy));
        chk("done_msb",  idx, 32'(done_m),  32'(e.edone));
        chk("done_lsb",  idx, 32'(done_l),  32'(e.edone));
        chk("sout_msb",  idx, 32'(sout_m),  32'(e.esout_m));
        chk("sout_lsb",  idx, 32'(sout_l),  32'(e.esout_l));
    endtask

    // Drive one cycle (called 1 time unit after a rising edge), then check
    // 1 time unit after the next rising edge.
    task automatic step(input vec_t v, input int idx);
        clear    = v.clear;
        load     = v.load;
        d        = v.d;
        shift_en = v.shift_en;
        sin      = v.sin;
        sb.push_back(v);
        @(posedge clk);
        #1;
        compare_head(idx);
    endtask

    // Check outputs without a clock edge (asynchronous reset behaviour)
    task automatic check_now(input vec_t v, input int idx);
        sb.push_back(v);
        #1;
        compare_head(idx);
    endtask

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t z;
        z = mk(0,0,8'h00,0,0, 8'h00,8'h00,0,0,0,0,0);

        reset = 1'b0; clear = 1'b0; load = 1'b0; d = '0; shift_en = 1'b0; sin = 1'b0;

        // ---- transfer table -------------------------------------------------
        // A: load 0xA5, eight shifts with sin=0, then idle guard
        vecs.push_back(mk(0,1,8'hA5,0,0, 8'hA5,8'hA5,0,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h4A,8'h52,1,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h94,8'h29,2,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h28,8'h14,3,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h50,8'h0A,4,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hA0,8'h05,5,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h40,8'h02,6,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h80,8'h01,7,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h00,8'h00,8,0,1,0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,8'h00,1,1, 8'h00,8'h00,8,0,0,0,0));
        // B: capture sin = 1,1,0,0,1,0,1,0
        vecs.push_back(mk(0,1,8'h00,0,0, 8'h00,8'h00,0,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1, 8'h01,8'h80,1,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1, 8'h03,8'hC0,2,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h06,8'h60,3,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h0C,8'h30,4,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1, 8'h19,8'h98,5,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h32,8'h4C,6,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1, 8'h65,8'hA6,7,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hCA,8'h53,8,0,1,1,1));
        // C: stall and restart
        vecs.push_back(mk(0,1,8'hFF,0,0, 8'hFF,8'hFF,0,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hFE,8'h7F,1,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hFC,8'h3F,2,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hF8,8'h1F,3,1,0,1,1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,8'h00,0,1, 8'hF8,8'h1F,3,1,0,1,1));
        vecs.push_back(mk(0,1,8'h3C,0,0, 8'h3C,8'h3C,0,1,0,0,0));
        // D: priority
        vecs.push_back(mk(0,1,8'h5A,1,1, 8'h5A,8'h5A,0,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1, 8'hB5,8'hAD,1,1,0,1,1));
        vecs.push_back(mk(1,1,8'hFF,1,1, 8'h00,8'h00,0,0,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1, 8'h00,8'h00,0,0,0,0,0));
        // E: restart on the cycle that would have been the last shift
        vecs.push_back(mk(0,1,8'hFF,0,0, 8'hFF,8'hFF,0,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hFE,8'h7F,1,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hFC,8'h3F,2,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hF8,8'h1F,3,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hF0,8'h0F,4,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hE0,8'h07,5,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'hC0,8'h03,6,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,1,0, 8'h80,8'h01,7,1,0,1,1));
        vecs.push_back(mk(0,1,8'h81,1,0, 8'h81,8'h81,0,1,0,1,1));
        vecs.push_back(mk(0,0,8'h00,0,0, 8'h81,8'h81,0,1,0,1,1));
        vecs.push_back(mk(1,0,8'h00,0,0, 8'h00,8'h00,0,0,0,0,0));

        // ---- reset state ---------------------------------------------------
        repeat (2) @(posedge clk);
        #1;
        check_now(z, 0);
        reset = 1'b1;   // released mid-cycle, 2 units after the edge

        // ---- table ---------------------------------------------------------
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], 100 + i);

        // ---- asynchronous reset mid-transfer -------------------------------
        step(mk(0,1,8'hA5,0,0, 8'hA5,8'hA5,0,1,0,1,1), 300);
        step(mk(0,0,8'h00,1,0, 8'h4A,8'h52,1,1,0,0,0), 301);
        step(mk(0,0,8'h00,1,0, 8'h94,8'h29,2,1,0,1,1), 302);
        #1;
        reset = 1'b0;                 // away from any clock edge
        check_now(z, 303);
        // Held in reset across edges with shift_en high
        step(mk(0,0,8'h00,1,1, 8'h00,8'h00,0,0,0,0,0), 304);
        step(mk(0,0,8'h00,1,1, 8'h00,8'h00,0,0,0,0,0), 305);
        #1;
        reset = 1'b1;
        // After release only a load starts a transfer; no late done pulse
        step(mk(0,0,8'h00,1,1, 8'h00,8'h00,0,0,0,0,0), 306);
        step(mk(0,0,8'h00,1,1, 8'h00,8'h00,0,0,0,0,0), 307);

        // ---- reset at the final shift: no done -----------------------------
        step(mk(0,1,8'hFF,0,0, 8'hFF,8'hFF,0,1,0,1,1), 310);
        for (int i = 0; i < 7; i++)
            step(mk(0,0,8'h00,1,0, 8'hFF << (i+1), 8'hFF >> (i+1), i+1,1,0,1,1), 311 + i);
        #1;
        reset = 1'b0;
        check_now(z, 318);

        // ---- reset release: first edge after release takes the load --------
        #1;
        reset = 1'b1;
        step(mk(0,1,8'hC3,1,1, 8'hC3,8'hC3,0,1,0,1,1), 320);
        step(mk(0,0,8'h00,1,0, 8'h86,8'h61,1,1,0,1,1), 321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_register_n.md
SHIFT_REGISTER_N -- requirements
Module: shift_register_n

Interface
REQ-001 SHALL have parameter N, default 8, meaning the register width in bits (N >= 2).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift toward MSB and 0 = shift toward LSB.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous clear of all state.
REQ-006 SHALL have port load, input, 1 bit: parallel load of d and start of a transfer.
REQ-007 SHALL have port d, input, N bits: parallel load data.
REQ-008 SHALL have port shift_en, input, 1 bit: advance one bit position this cycle.
REQ-009 SHALL have port sin, input, 1 bit: serial data in.
REQ-010 SHALL have port q, output, N bits: register contents.
REQ-011 SHALL have port sout, output, 1 bit: serial data out.
REQ-012 SHALL have port count, output, $clog2(N+1) bits: shifts completed in the current transfer.
REQ-013 SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the transfer completes.

Function
REQ-015 SHALL implement a two-state FSM.
- IDLE: busy=0.
- SHIFT: busy=1.
- busy SHALL be decoded from state.
REQ-016 SHALL apply per-cycle priority clear > load > shift_en.
REQ-017 On clear=1 SHALL set q=0, count=0, state=IDLE and done=0, in either state.
REQ-018 On load=1 with clear=0 SHALL set q=d, count=0, state=SHIFT and done=0, in either state. A load during SHIFT restarts the transfer and SHALL NOT assert done.
REQ-019 In SHIFT with shift_en=1 and MSB_FIRST=1 SHALL set q={q[N-2:0],sin}.
REQ-020 In SHIFT with shift_en=1 and MSB_FIRST=0 SHALL set q={sin,q[N-1:1]}.
REQ-021 Every SHIFT cycle with shift_en=1 SHALL increment count by 1.
REQ-022 In SHIFT with shift_en=0 SHALL hold q and count; stalls of any length are allowed.
REQ-023 On the shift that makes count==N SHALL, in the same edge:
- set state=IDLE;
- register done=1 for exactly one cycle;
- hold count at N until the next load or clear.
REQ-024 In IDLE SHALL ignore shift_en: q, count and done unchanged except done returns to 0.
REQ-025 sout SHALL be combinational from q: q[N-1] if MSB_FIRST=1, else q[0]. The first serial bit is valid in the cycle after load.
REQ-026 count SHALL never exceed N and SHALL never wrap.
REQ-027 done SHALL be 0 in every cycle not covered by REQ-023.

Reset
REQ-028 While reset=0 SHALL asynchronously force q=0, count=0, state=IDLE, busy=0, done=0 and sout=0, independent of clk.
REQ-029 Reset asserted mid-transfer SHALL abort it with no done pulse. After release, only load starts a new transfer.
REQ-030 Reset release SHALL take effect at the first rising clk edge after reset goes high, with no extra latency.

Verification
REQ-031 Reset: reset=0 at any time, including mid-shift -> q=0x00, count=0, busy=0, done=0 immediately; no done pulse afterwards.
REQ-032 MSB_FIRST=1, N=8: load d=0xA5, sin=0, 8 consecutive shift_en -> sout seen before each shift = 1,0,1,0,0,1,0,1; final q=0x00, count=8; done=1 for exactly the cycle after the 8th shift edge; busy=0 thereafter.
REQ-033 Capture: load 0x00, then sin=1,1,0,0,1,0,1,0 on 8 shifts -> q=0xCA. With MSB_FIRST=0 the same stimulus -> q=0x53.
REQ-034 Stall and restart: load 0xFF, 3 shifts, shift_en=0 for 5 cycles -> q and count=3 held. Then load 0x3C -> q=0x3C, count=0, busy=1, no done.
REQ-035 Priority: clear=1, load=1 and shift_en=1 in the same cycle -> q=0, IDLE. Load with shift_en=1 -> q=d, count=0, no shift applied.
REQ-036 Idle guard: after done, apply 4 shift_en pulses -> q, count=8 and busy=0 unchanged; done stays 0.
